// File: rtl/block_memory_responder.sv
// Cycle-accurate main memory below the cache controllers.
// Serves block fills, block writebacks and word writes with a fixed LATENCY per request.
module block_memory_responder #(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req,
  input  logic [1:0]   op,
  input  logic [9:0]   addr,
  input  logic [31:0]  wdata_word,
  input  logic [127:0] wdata_block,
  output logic         ready,
  output logic         done,
  output logic [127:0] rdata_block
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WORD  = 2'b01;
  localparam logic [1:0] OP_BLOCK = 2'b10;

  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]   state;
  logic [3:0]   count;
  logic [1:0]   op_held;
  logic [7:0]   word_addr;
  logic [31:0]  word_held;
  logic [127:0] block_held;
  logic [5:0]   blk;
  logic         commit;
  logic [31:0]  mem_rd [MEM_WORDS];
  logic         unused_byte_offset;

  assign unused_byte_offset = ^addr[1:0];
  assign blk    = word_addr[7:2];
  assign ready  = (state == IDLE);
  assign done   = (state == RESP);
  assign commit = (state == BUSY) && (count == 4'd0);

  // Request is captured whole at acceptance so later input changes cannot leak in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      op_held     <= '0;
      word_addr   <= '0;
      word_held   <= '0;
      block_held  <= '0;
      rdata_block <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_held    <= op;
            word_addr  <= addr[9:2];
            word_held  <= wdata_word;
            block_held <= wdata_block;
            count      <= COUNT_LOAD;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            state <= RESP;
            if (op_held == OP_READ) begin
              rdata_block <= {mem_rd[{blk, 2'd3}], mem_rd[{blk, 2'd2}],
                              mem_rd[{blk, 2'd1}], mem_rd[{blk, 2'd0}]};
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is per-word so each word carries its own power-up value and reset never touches it.
  for (genvar i = 0; i < MEM_WORDS; i++) begin : g_word
    logic [31:0] value = 32'(i);
    logic        we;
    logic [31:0] wd;

    always_comb begin
      we = 1'b0;
      wd = word_held;
      if (commit) begin
        if (op_held == OP_WORD && word_addr == 8'(i)) begin
          we = 1'b1;
        end else if (op_held == OP_BLOCK && blk == 6'(i / 4)) begin
          we = 1'b1;
          wd = block_held[32 * (i % 4) +: 32];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (we) value <= wd;
    end

    assign mem_rd[i] = value;
  end

endmodule

// File: tb/tb_block_memory_responder.sv
// Randomised scoreboard bench for block_memory_responder.
// Driver predicts each response from a word-array model; a negedge monitor checks done timing, data and ready.
module tb_block_memory_responder #(
  parameter int LAT = 4
);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req = 1'b0;
  logic [1:0]   op = '0;
  logic [9:0]   addr = '0;
  logic [31:0]  wdata_word = '0;
  logic [127:0] wdata_block = '0;
  logic         ready;
  logic         done;
  logic [127:0] rdata_block;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int           due;
    logic [127:0] data;
  } exp_t;

  exp_t         sb[$];
  bit           abort_pending = 1'b0;
  logic [31:0]  model_mem [256];
  logic [127:0] last_read = '0;

  block_memory_responder #(.LATENCY(LAT), .MEM_WORDS(256)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .op(op), .addr(addr),
    .wdata_word(wdata_word), .wdata_block(wdata_block),
    .ready(ready), .done(done), .rdata_block(rdata_block)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: got no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] model_block(input logic [5:0] b);
    return {model_mem[{b, 2'd3}], model_mem[{b, 2'd2}], model_mem[{b, 2'd1}], model_mem[{b, 2'd0}]};
  endfunction

  // Any request outstanding in the scoreboard means the responder must report not-ready.
  always @(negedge clk) begin
    if (reset_n) begin
      automatic bit exp_ready = (sb.size() == 0) && !abort_pending;
      checks++;
      if (ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL ready cyc=%0d: got %b required %b", cyc, ready, exp_ready);
      end
      if (done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL done_spurious cyc=%0d: got done=1 required done=0", cyc);
        end else begin
          automatic exp_t e = sb.pop_front();
          if (cyc != e.due) begin
            errors++;
            $display("[TB] FAIL done_time: got cycle %0d required cycle %0d", cyc, e.due);
          end
          checks++;
          if (rdata_block !== e.data) begin
            errors++;
            $display("[TB] FAIL rdata cyc=%0d: got %h required %h", cyc, rdata_block, e.data);
          end
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_missing cyc=%0d: got done=0 required done=1", cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [9:0] a, input logic [31:0] w,
                               input logic [127:0] b, input bit track);
    int budget = 0;
    int accept_neg;
    @(negedge clk);
    while (ready !== 1'b1 && budget < 100) begin
      if ($urandom_range(0, 1) == 1) begin
        req = 1'b1; op = 2'b01; addr = 10'h000; wdata_word = $urandom;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got ready=%b required ready=1", ready);
      req = 1'b0;
      return;
    end
    req = 1'b1; op = o; addr = a; wdata_word = w; wdata_block = b;
    accept_neg = cyc;
    @(posedge clk);
    #1;
    req = 1'b0; op = 2'($urandom); addr = 10'($urandom);
    wdata_word = $urandom; wdata_block = {$urandom, $urandom, $urandom, $urandom};
    if (track) begin
      case (o)
        2'b00: last_read = model_block(a[9:4]);
        2'b01: model_mem[a[9:2]] = w;
        2'b10: for (int k = 0; k < 4; k++) model_mem[{a[9:4], 2'(k)}] = b[32*k +: 32];
        default: ;
      endcase
      sb.push_back('{due: accept_neg + 1 + LAT, data: last_read});
    end else begin
      abort_pending = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  initial begin
    logic [127:0] blk_a;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'(i);

    #1;
    checkOutput("reset_ready", 128'(ready), 128'(1));
    checkOutput("reset_done", 128'(done), 128'(0));
    checkOutput("reset_rdata", rdata_block, 128'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(2'b00, 10'h010, 32'h0, 128'h0, 1'b1);
    applyStimulus(2'b01, 10'h3FE, 32'hDEADBEEF, 128'h0, 1'b1);
    applyStimulus(2'b00, 10'h3F0, 32'h0, 128'h0, 1'b1);
    blk_a = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    applyStimulus(2'b10, 10'h120, 32'h0, blk_a, 1'b1);
    applyStimulus(2'b00, 10'h12C, 32'h0, 128'h0, 1'b1);
    applyStimulus(2'b00, 10'h110, 32'h0, 128'h0, 1'b1);
    applyStimulus(2'b11, 10'h000, 32'h12345678, {4{32'h55AA55AA}}, 1'b1);
    applyStimulus(2'b00, 10'h000, 32'h0, 128'h0, 1'b1);

    // Writeback aborted by reset must never reach the array.
    applyStimulus(2'b10, 10'h000, 32'h0, {4{32'hBAD0BAD0}}, 1'b0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    abort_pending = 1'b0;
    sb.delete();
    last_read = '0;
    #1;
    checkOutput("abort_ready", 128'(ready), 128'(1));
    checkOutput("abort_done", 128'(done), 128'(0));
    checkOutput("abort_rdata", rdata_block, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(2'b00, 10'h003, 32'h0, 128'h0, 1'b1);

    repeat (60) begin
      automatic logic [9:0] a = ($urandom_range(0, 1) == 1) ? {6'($urandom_range(0, 3)), 4'($urandom)}
                                                             : 10'($urandom);
      applyStimulus(2'($urandom_range(0, 3)), a, $urandom,
                    {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    end

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d outstanding required 0", sb.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_memory_responder.md
Name: block_memory_responder

Overview:
- Clocked main-memory responder that serves the cache's block-granular traffic over a req/ready/done handshake with fixed, parameterised access latency.
- Services block fills (128-bit read), dirty-block writebacks (128-bit write) and single-word writes.
- Sits directly below the cache controllers and replaces the combinational main memory model with a cycle-accurate one.

Parameters:
- LATENCY, 4, cycles from request acceptance to done; legal range 1..15.
- MEM_WORDS, 256, number of 32-bit words; byte address width is 10.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  1  request strobe, sampled only when ready=1
- op  input  2  00 block read, 01 word write, 10 block write, 11 reserved
- addr  input  10  byte address; [9:4] block, [3:2] word, [1:0] ignored
- wdata_word  input  32  data for word write
- wdata_block  input  128  data for block write; word0 in [31:0], word3 in [127:96]
- ready  output  1  high when idle and able to accept a request
- done  output  1  one-cycle completion pulse
- rdata_block  output  128  block read data, same packing as wdata_block

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE, ready=1, done=0, rdata_block=0, latency counter=0.
- Reset does not touch the storage array.
- Array simulation initialiser: word i = i (32-bit).
- States and transitions:
  - IDLE: ready=1, done=0. On req=1, latch op, addr[9:2], wdata_word and wdata_block; load counter with LATENCY-1; go BUSY.
  - BUSY: ready=0. While counter≠0, decrement. When counter=0, perform the operation at this edge and go RESP.
  - RESP: done=1, ready=0 for exactly one cycle, then IDLE.
- Latency:
  - Request accepted at edge E0; operation commits at edge E0+LATENCY; done is high in the cycle following that edge.
  - The next request can be accepted at edge E0+LATENCY+1, giving a throughput of one request per LATENCY+1 cycles.
- Block read: rdata_block = {mem[b*4+3], mem[b*4+2], mem[b*4+1], mem[b*4]} with b = latched addr[9:4]. The value is updated at the commit edge and held until the next block read commits.
- Word write: mem[latched addr[9:2]] = wdata_word; rdata_block unchanged.
- Block write: all four words of block b are written from the latched wdata_block; rdata_block unchanged.
- Op 11: no array change, rdata_block unchanged; still completes with the normal latency and done pulse.
- Input changes after acceptance have no effect, because everything is latched at acceptance.
- req while ready=0 is ignored: not queued and not an error. The requester must hold req until it sees ready=1 at an edge.
- Writes committed at an edge are visible to any read accepted at a later edge, so read-after-write and writeback-then-fill to the same block return the new data.
- Reset mid-operation (BUSY or RESP): the operation is aborted; a write not yet committed is never performed; outputs take their reset values.
- addr[1:0] has no effect on any operation.

Test Plan:
- After reset, LATENCY=4: block read of addr 0x010 accepted at edge E0 -> done high exactly one cycle after edge E0+4; rdata_block = {32'd7, 32'd6, 32'd5, 32'd4}; ready low from E0+1 until done falls.
- Word write 0xDEADBEEF to addr 0x3FE, then block read of 0x3F0 -> word3 = 0xDEADBEEF, words 0..2 = 252, 253, 254; addr[1:0]=2'b10 is ignored.
- Block write of {A3, A2, A1, A0} to addr 0x120, then block read of 0x12C -> rdata_block returns the same 128 bits; neighbouring block 0x110 is unchanged (words 68..71).
- req pulsed during BUSY with op=01 to addr 0 -> no write to mem[0]; only one done pulse; a later read of block 0 returns {3, 2, 1, 0}.
- Block write accepted, reset_n pulsed low during BUSY -> ready=1, done=0, rdata_block=0 immediately; a subsequent read shows the original contents.
- LATENCY=1 build: back-to-back reads of blocks 0 and 1 -> done one cycle after each acceptance edge; accepts spaced 2 cycles apart; op=11 produces a done pulse with no data change.
